truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential, parametrised successor to our hand-written truth-table benches for 3-input gate/operator modules.
- Drives every N_IN-bit input combination into up to N_CH combinational DUT channels in parallel.
- Compares each channel output against a supplied expected truth table and reports per-channel pass/fail, mismatch count and first failing vector.
- Synthesisable, so the same checker runs on the board with switches/LEDs as well as in simulation.

Parameters:
- N_IN, 3: input bits per vector; sweep covers 2^N_IN vectors.
- N_CH, 6: number of DUT channels checked in parallel.
- HOLD, 1: clock cycles each vector is held (>=1); sample taken on the last one.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  terminate sweep; return to IDLE
- exp_tt  in  N_CH*2^N_IN  expected outputs; bit [c*2^N_IN + v] = channel c, vector v
- dut_y  in  N_CH  DUT outputs; bit c = channel c
- vec  out  N_IN  registered vector driven to all DUT inputs
- busy  out  1  high during APPLY
- done  out  1  one-cycle pulse at sweep completion
- pass  out  1  high when last completed sweep had zero mismatches
- err_mask  out  N_CH  sticky per-channel mismatch flags
- err_count  out  N_IN+1  vectors with at least one mismatching channel
- first_fail_vec  out  N_IN  vector value of first mismatch
- first_fail_valid  out  1  first_fail_vec is meaningful

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - vec, busy, done, pass, err_mask, err_count, first_fail_vec, first_fail_valid all 0.
- States: IDLE, APPLY, DONE.
- IDLE -> APPLY:
  - Edge with start=1 sets vec=0 (first step), hold_cnt=0 and busy=1.
  - Same edge clears err_mask, err_count, pass, first_fail_valid.
- APPLY, hold_cnt < HOLD-1: hold_cnt++ and vec held.
- APPLY, hold_cnt == HOLD-1 (sample edge):
  - mis = dut_y XOR exp bits for current vec.
  - err_mask |= mis.
  - If mis != 0: err_count++. If first_fail_valid=0, also latch first_fail_vec=vec and set first_fail_valid=1.
  - If last step: go to DONE, busy=0. Otherwise advance vec, hold_cnt=0.
- DONE: done=1 for exactly one cycle and pass=(err_count==0). Next edge returns to IDLE with done=0.
- Latency: done is high in the cycle starting at edge k+2^N_IN*HOLD, where k is the start edge.
- vec returns to 0 on entering IDLE. Results are held stable until the next accepted start.
- err_count never overflows: max 2^N_IN fits in N_IN+1 bits.
- start while busy or in DONE: ignored.
- abort in APPLY: next edge goes to IDLE with busy=0 and vec=0. No done pulse; pass stays 0; partial err_* retained.
- abort in IDLE or DONE: no effect; DONE still completes.
- start and abort together in IDLE: start wins. Together in APPLY: abort wins.
- rst_n low mid-sweep: immediate return to reset values, independent of clk.
- dut_y is assumed combinationally settled within one cycle of vec changing when HOLD=1.

Optional Feature:
- Macro SWEEP_GRAY_EN.
- Defined: step s drives vec = s ^ (s>>1) (Gray order), so consecutive vectors differ in one bit. exp_tt is still indexed by vector value. first_fail_vec reports the vector value, not the step.
- Undefined: vec = s (binary order).
- Timing and all other behaviour are identical in both builds.

Test Plan:
- Correct DUTs, N_IN=3, N_CH=2, HOLD=1; ch0=AND3 with exp 8'h80, ch1=OR3 with exp 8'hFE; pulse start -> vec steps 0..7; done 8 cycles after start edge; pass=1, err_count=0, err_mask=2'b00.
- Same setup, ch1 stuck-at-0 -> err_mask=2'b10, err_count=7, first_fail_vec=3'd1, first_fail_valid=1, pass=0.
- HOLD=3 -> each vec held 3 cycles; done exactly 24 cycles after start edge; sampling on third cycle only, checked by a DUT output glitching wrong in cycles 1-2 yet still giving pass=1.
- abort asserted while vec=4 -> next cycle busy=0, vec=0, no done pulse; then start pulsed during busy of a new sweep is ignored (sweep length unchanged).
- rst_n pulled low at vec=5 between clock edges -> all outputs 0 immediately; fresh start afterwards gives a full correct sweep.
- SWEEP_GRAY_EN defined -> vec sequence 0,1,3,2,6,7,5,4. With ch0 wrong only at vector 6 -> first_fail_vec=3'd6, err_count=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Purpose : sweeps every N_IN-bit vector into N_CH combinational channels and checks each against a truth table.
// Latency : done pulses in the cycle starting 2^N_IN*HOLD edges after the accepted start edge.
// Backpr. : none; start is honoured only in IDLE, abort only in APPLY (abort beats start in APPLY).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin sweep (IDLE only) / terminate sweep (APPLY only)
//   exp_tt              expected outputs, bit [c*2^N_IN + v] = channel c at vector v
//   dut_y               observed channel outputs, bit c = channel c
//   vec                 registered vector driven to every channel's inputs
//   busy, done          sweep in progress / one-cycle completion pulse
//   pass                last completed sweep had no mismatching vector
//   err_mask            sticky per-channel mismatch flags
//   err_count           number of vectors with at least one mismatching channel
//   first_fail_vec/_valid  vector value of the first mismatch seen and its qualifier
//
// Build option: define SWEEP_GRAY_EN to step vectors in Gray order (one bit change per step).

module truth_table_sweeper #(
    parameter int N_IN = 3,
    parameter int N_CH = 6,
    parameter int HOLD = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [N_CH*(1<<N_IN)-1:0]    exp_tt,
    input  logic [N_CH-1:0]              dut_y,
    output logic [N_IN-1:0]              vec,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_CH-1:0]              err_mask,
    output logic [N_IN:0]                err_count,
    output logic [N_IN-1:0]              first_fail_vec,
    output logic                         first_fail_valid
);

    localparam int NV = 1 << N_IN;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] STEP_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   step_q, step_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffok_q, ffok_d;
    logic              pass_q, pass_d;

    // Per-channel view of the expected table, one NV-bit row per channel.
    logic [NV-1:0]     exp_row [N_CH];
    logic [N_CH-1:0]   exp_cur;
    logic [N_CH-1:0]   mis;

    // Sweep step to vector value. The expected table is always indexed by
    // the vector value, so the step order only affects what is driven.
    function automatic logic [N_IN-1:0] step_to_vec(input logic [N_IN-1:0] s);
`ifdef SWEEP_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    for (genvar c = 0; c < N_CH; c++) begin : g_row
        assign exp_row[c] = exp_tt[c*NV +: NV];
    end

    always_comb begin
        exp_cur = '0;
        for (int c = 0; c < N_CH; c++) begin
            exp_cur[c] = exp_row[c][vec_q];
        end
    end

    assign mis = dut_y ^ exp_cur;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            hold_q  <= '0;
            vec_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            ffv_q   <= '0;
            ffok_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffok_q  <= ffok_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        ffv_d   = ffv_q;
        ffok_d  = ffok_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    step_d  = '0;
                    hold_d  = '0;
                    vec_d   = step_to_vec('0);
                    mask_d  = '0;
                    cnt_d   = '0;
                    ffok_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end

            S_APPLY: begin
                if (abort) begin
                    // Partial results stay visible; nothing is sampled on this edge.
                    state_d = S_IDLE;
                    step_d  = '0;
                    hold_d  = '0;
                    vec_d   = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    // Sample edge: only the last hold cycle is compared, so the
                    // channels have HOLD cycles to settle after vec changes.
                    mask_d = mask_q | mis;
                    if (mis != '0) begin
                        cnt_d = cnt_q + 1'b1;
                        if (!ffok_q) begin
                            ffv_d  = vec_q;
                            ffok_d = 1'b1;
                        end
                    end
                    if (step_q == STEP_LAST) begin
                        state_d = S_DONE;
                        pass_d  = (cnt_d == '0);
                    end else begin
                        step_d = step_q + 1'b1;
                        vec_d  = step_to_vec(step_q + 1'b1);
                        hold_d = '0;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                step_d  = '0;
                hold_d  = '0;
                vec_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign vec              = vec_q;
    assign busy             = (state_q == S_APPLY);
    assign done             = (state_q == S_DONE);
    assign pass             = pass_q;
    assign err_mask         = mask_q;
    assign err_count        = cnt_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffok_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose : exercises truth_table_sweeper with HOLD=1 and HOLD=3 instances, two channels of 3 inputs.
// Latency : results are predicted per sweep from the tables and compared at the done pulse.
// Backpr. : n/a; channel behaviour is a table lookup on vec, optionally glitched during settle cycles.

module tb_truth_table_sweeper;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        sel   = 1'b0;   // 0: HOLD=1 instance, 1: HOLD=3 instance

    logic [7:0]  exp_row [2];
    logic [7:0]  act_row [2];
    logic [15:0] exp_tt;

    logic        start1, start3, abort1, abort3;
    logic [1:0]  dut_y1, dut_y3;
    logic [1:0]  ph = 2'd0;
    logic        glitch;

    logic [2:0]  vec1, vec3, ffv1, ffv3;
    logic        busy1, busy3, done1, done3, pass1, pass3, ffok1, ffok3;
    logic [1:0]  mask1, mask3;
    logic [3:0]  cnt1, cnt3;

    logic [2:0]  o_vec, o_ffv;
    logic        o_busy, o_done, o_pass, o_ffok;
    logic [1:0]  o_mask;
    logic [3:0]  o_cnt;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign exp_tt = {exp_row[1], exp_row[0]};
    assign start1 = start & ~sel;
    assign start3 = start & sel;
    assign abort1 = abort & ~sel;
    assign abort3 = abort & sel;

    // Channels under test: plain table lookups on the applied vector.
    assign dut_y1 = {act_row[1][vec1], act_row[0][vec1]};

    // Hold phase of the HOLD=3 sweep; outputs are deliberately wrong until
    // the third cycle of each vector.
    always @(posedge clk) begin
        if (start3) ph <= 2'd0;
        else        ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
    end
    assign glitch = (ph != 2'd2);
    assign dut_y3 = {act_row[1][vec3], act_row[0][vec3]} ^ {2{glitch}};

    truth_table_sweeper #(.N_IN(3), .N_CH(2), .HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .exp_tt(exp_tt), .dut_y(dut_y1), .vec(vec1), .busy(busy1), .done(done1),
        .pass(pass1), .err_mask(mask1), .err_count(cnt1),
        .first_fail_vec(ffv1), .first_fail_valid(ffok1)
    );

    truth_table_sweeper #(.N_IN(3), .N_CH(2), .HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .exp_tt(exp_tt), .dut_y(dut_y3), .vec(vec3), .busy(busy3), .done(done3),
        .pass(pass3), .err_mask(mask3), .err_count(cnt3),
        .first_fail_vec(ffv3), .first_fail_valid(ffok3)
    );

    assign o_vec  = sel ? vec3  : vec1;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_pass = sel ? pass3 : pass1;
    assign o_mask = sel ? mask3 : mask1;
    assign o_cnt  = sel ? cnt3  : cnt1;
    assign o_ffv  = sel ? ffv3  : ffv1;
    assign o_ffok = sel ? ffok3 : ffok1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Vector driven at sweep step s.
    function automatic logic [2:0] order(input int s);
        logic [2:0] b;
        b = 3'(s);
`ifdef SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Runs one full sweep on the selected instance and checks it against a
    // prediction made straight from the two tables.
    task automatic run_sweep(input bit s3, input bit midstart);
        int         hold;
        logic [1:0] em;
        int         ec;
        logic       eok;
        logic [2:0] effv;
        logic [2:0] v;
        logic [1:0] m;

        hold = s3 ? 3 : 1;
        em = 2'b00; ec = 0; eok = 1'b0; effv = 3'd0;
        for (int s = 0; s < 8; s++) begin
            v = order(s);
            m = {act_row[1][v] ^ exp_row[1][v], act_row[0][v] ^ exp_row[0][v]};
            em |= m;
            if (m != 2'b00) begin
                ec++;
                if (!eok) begin
                    eok  = 1'b1;
                    effv = v;
                end
            end
        end

        sel = s3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 8 * hold; j++) begin
            check("sweep_vec",  32'(o_vec),  32'(order(j / hold)));
            check("sweep_busy", 32'(o_busy), 32'd1);
            check("sweep_done", 32'(o_done), 32'd0);
            start = (midstart && j == 3);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", 32'(o_done), 32'd1);
        check("done_busy",  32'(o_busy), 32'd0);
        check("pass",       32'(o_pass), 32'(ec == 0));
        check("err_mask",   32'(o_mask), 32'(em));
        check("err_count",  32'(o_cnt),  32'(ec));
        check("ff_valid",   32'(o_ffok), 32'(eok));
        if (eok) check("ff_vec", 32'(o_ffv), 32'(effv));
        @(negedge clk);
        check("after_done",  32'(o_done), 32'd0);
        check("after_vec",   32'(o_vec),  32'd0);
        check("held_count",  32'(o_cnt),  32'(ec));
        check("held_pass",   32'(o_pass), 32'(ec == 0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},  32'(o_vec),  32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_pass"}, 32'(o_pass), 32'd0);
        check({tag, "_mask"}, 32'(o_mask), 32'd0);
        check({tag, "_cnt"},  32'(o_cnt),  32'd0);
        check({tag, "_ffv"},  32'(o_ffv),  32'd0);
        check({tag, "_ffok"}, 32'(o_ffok), 32'd0);
    endtask

    initial begin
        bit found;
        int seen_done;

        exp_row[0] = 8'h80; exp_row[1] = 8'hFE;
        act_row[0] = 8'h80; act_row[1] = 8'hFE;

        // Reset values.
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // AND3 / OR3, both correct.
        run_sweep(1'b0, 1'b0);

        // OR3 channel stuck at 0.
        act_row[1] = 8'h00;
        run_sweep(1'b0, 1'b0);

        // AND3 wrong only at vector 6.
        act_row[0] = 8'h80 ^ 8'h40;
        act_row[1] = 8'hFE;
        run_sweep(1'b0, 1'b0);

        // HOLD=3 with glitching outputs during settle cycles, tables correct.
        act_row[0] = 8'h80; act_row[1] = 8'hFE;
        run_sweep(1'b1, 1'b0);

        // Abort at vec=4 with channel 0 wrong at vector 2.
        act_row[0] = 8'h80 ^ 8'h04;
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            if (o_vec == 3'd4) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_reach", 32'(found), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_vec",  32'(o_vec),  32'd0);
        check("abort_pass", 32'(o_pass), 32'd0);
        check("abort_cnt",  32'(o_cnt),  32'd1);
        check("abort_mask", 32'(o_mask), 32'd1);
        check("abort_ffv",  32'(o_ffv),  32'd2);
        seen_done = 0;
        for (int j = 0; j < 10; j++) begin
            if (o_done) seen_done++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen_done), 32'd0);

        // Start pulsed mid-sweep must not change sweep length.
        act_row[0] = 8'h80;
        run_sweep(1'b0, 1'b1);

        // Reset between edges mid-sweep.
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        act_row[1] = 8'h0E;   // mismatches before vector 5 so the results are non-zero
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            if (o_vec == 3'd5) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_reach", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        act_row[1] = 8'hFE;
        run_sweep(1'b0, 1'b0);

        // Randomised tables on both instances.
        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < 2; c++) begin
                exp_row[c] = 8'($urandom);
                if (i % 4 == 0) act_row[c] = exp_row[c];
                else act_row[c] = exp_row[c] ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            end
            run_sweep(i >= 11, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
